// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
// Shared constants and types for the integer/floating-point blocks.
//   FLOAT_WIDTH : width of an IEEE-754 single-precision word
//   EXP_BIAS    : single-precision exponent bias
//   MANT_WIDTH  : mantissa width including the hidden leading one
//   state_e     : sequencing states of the multi-cycle converters
//   pack_float  : assembles {sign, biased exponent, fraction}
// -----------------------------------------------------------------------------
package float_pkg;

   localparam int FLOAT_WIDTH = 32;
   localparam int EXP_BIAS    = 127;
   localparam int MANT_WIDTH  = 24;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CONVERT   = 3'd1,
      NORMALISE = 3'd2,
      ROUND     = 3'd3,
      DONE      = 3'd4
   } state_e;

   function automatic logic [FLOAT_WIDTH-1:0] pack_float(
      input logic                  sign,
      input logic [7:0]            biased_exp,
      input logic [MANT_WIDTH-2:0] frac
   );
      return {sign, biased_exp, frac};
   endfunction

endpackage : float_pkg

// File: rtl/float_round.sv
// -----------------------------------------------------------------------------
// float_round
// Combinational mantissa rounding stage, shared by the float datapaths.
// Build option: INT_TO_FLOAT_ROUND_EN
//   defined   : round-to-nearest-even with carry into the exponent
//   undefined : truncation, inputs pass straight through
// Ports:
//   mant_i   : 24-bit mantissa (hidden one in bit 23)
//   guard_i  : first bit below the mantissa LSB
//   round_i  : second bit below the mantissa LSB
//   sticky_i : OR of all remaining lower bits
//   exp_i    : unbiased exponent
//   mant_o   : rounded mantissa
//   exp_o    : exponent, incremented when rounding carries out
// -----------------------------------------------------------------------------
module float_round
   import float_pkg::*;
(
   input  logic [MANT_WIDTH-1:0] mant_i,
   input  logic                  guard_i,
   input  logic                  round_i,
   input  logic                  sticky_i,
   input  logic signed [7:0]     exp_i,
   output logic [MANT_WIDTH-1:0] mant_o,
   output logic signed [7:0]     exp_o
);

`ifdef INT_TO_FLOAT_ROUND_EN
   logic                round_up;
   logic [MANT_WIDTH:0] mant_sum;

   // Nearest-even: a tie (guard only) rounds up only when the LSB is odd.
   assign round_up = guard_i & (round_i | sticky_i | mant_i[0]);
   assign mant_sum = {1'b0, mant_i} + {{MANT_WIDTH{1'b0}}, round_up};

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      mant_o = mant_sum[MANT_WIDTH-1:0];
      exp_o  = exp_i;
      if (mant_sum[MANT_WIDTH]) begin
         // All-ones mantissa rolled over: renormalise to 1.0 x 2^(e+1).
         mant_o = {1'b1, {(MANT_WIDTH-1){1'b0}}};
         exp_o  = exp_i + 8'sd1;
      end
   end
`else
   logic unused_round_bits;

   assign unused_round_bits = ^{guard_i, round_i, sticky_i};
   assign mant_o            = mant_i;
   assign exp_o             = exp_i;
`endif

endmodule : float_round

// File: rtl/int_to_float.sv
// -----------------------------------------------------------------------------
// int_to_float
// Sequential 32-bit signed integer to IEEE-754 single-precision converter.
// Takes the absolute value, normalises one bit per cycle, then rounds.
// Build option: INT_TO_FLOAT_ROUND_EN selects round-to-nearest-even;
// without it the mantissa is truncated (latency is identical).
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   input_a      : signed integer operand
//   input_a_stb  : operand valid
//   input_a_ack  : registered, block can accept an operand
//   output_z     : single-precision result, held while output_z_stb is high
//   output_z_stb : registered, result valid
//   output_z_ack : downstream accepts the result
// -----------------------------------------------------------------------------
module int_to_float
   import float_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [FLOAT_WIDTH-1:0] input_a,
   input  logic                   input_a_stb,
   output logic                   input_a_ack,
   output logic [FLOAT_WIDTH-1:0] output_z,
   output logic                   output_z_stb,
   input  logic                   output_z_ack
);

   state_e                 state_q;
   logic [FLOAT_WIDTH-1:0] a_q;
   logic                   sign_q;
   logic [FLOAT_WIDTH-1:0] value_q;
   logic signed [7:0]      exp_q;
   logic [FLOAT_WIDTH-1:0] z_q;
   logic                   ack_q;
   logic                   stb_q;

   logic [MANT_WIDTH-1:0]  rnd_mant;
   logic signed [7:0]      rnd_exp;
   logic [7:0]             biased_exp;
   logic                   unused_hidden_bit;

   // Normalised value_q: bits 31:8 are the mantissa, 7 guard, 6 round, rest sticky.
   float_round u_round (
      .mant_i   (value_q[31:8]),
      .guard_i  (value_q[7]),
      .round_i  (value_q[6]),
      .sticky_i (|value_q[5:0]),
      .exp_i    (exp_q),
      .mant_o   (rnd_mant),
      .exp_o    (rnd_exp)
   );

   // Exponent stays within [0, 31] unbiased, so 8 bits hold the biased form.
   assign biased_exp        = rnd_exp + 8'(EXP_BIAS);
   // The leading one is implicit in the packed format.
   assign unused_hidden_bit = rnd_mant[MANT_WIDTH-1];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         sign_q  <= 1'b0;
         value_q <= '0;
         exp_q   <= '0;
         z_q     <= '0;
         ack_q   <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (input_a_stb && ack_q) begin
                  a_q     <= input_a;
                  ack_q   <= 1'b0;
                  state_q <= CONVERT;
               end else begin
                  ack_q <= 1'b1;
               end
            end

            CONVERT: begin
               if (a_q == '0) begin
                  z_q     <= '0;
                  stb_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  sign_q  <= a_q[FLOAT_WIDTH-1];
                  // -2^31 negates to itself, which is the correct unsigned magnitude.
                  value_q <= a_q[FLOAT_WIDTH-1] ? (~a_q + 32'd1) : a_q;
                  exp_q   <= 8'sd31;
                  state_q <= NORMALISE;
               end
            end

            NORMALISE: begin
               if (value_q[FLOAT_WIDTH-1]) begin
                  state_q <= ROUND;
               end else begin
                  value_q <= value_q << 1;
                  exp_q   <= exp_q - 8'sd1;
               end
            end

            ROUND: begin
               z_q     <= pack_float(sign_q, biased_exp, rnd_mant[MANT_WIDTH-2:0]);
               stb_q   <= 1'b1;
               state_q <= DONE;
            end

            DONE: begin
               if (output_z_ack) begin
                  stb_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign input_a_ack  = ack_q;
   assign output_z     = z_q;
   assign output_z_stb = stb_q;

endmodule : int_to_float

// File: tb/tb_int_to_float.sv
// -----------------------------------------------------------------------------
// tb_int_to_float
// Self-checking bench for int_to_float. Vector table holds both the
// round-to-nearest-even and truncated results; the column used follows
// INT_TO_FLOAT_ROUND_EN. Expected results travel through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_int_to_float;

   logic        clk;
   logic        rst_n;
   logic [31:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   int unsigned cyc;
   int unsigned accept_cyc;
   int          n_pass;
   int          n_total;
   logic [31:0] sb[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] z_rne;
      logic [31:0] z_trunc;
      int          lat;
   } vec_t;

   vec_t vecs[13];

   int_to_float dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] pick(input vec_t v);
`ifdef INT_TO_FLOAT_ROUND_EN
      return v.z_rne;
`else
      return v.z_trunc;
`endif
   endfunction

   // Wait for input_a_ack, present the operand for one accepting edge.
   task automatic drive_op(input logic [31:0] a, input logic [31:0] exp);
      int n = 0;
      @(negedge clk);
      while (!input_a_ack && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ack_ready", {31'd0, input_a_ack}, 32'd1);
      input_a     = a;
      input_a_stb = 1'b1;
      @(posedge clk);
      #1;
      accept_cyc  = cyc;
      input_a_stb = 1'b0;
      sb.push_back(exp);
   endtask

   // Wait for the result, check latency and value, optionally stall, then ack.
   task automatic wait_result(input string name, input int exp_lat, input int hold);
      logic [31:0] exp;
      int          lat;
      @(negedge clk);
      while (!output_z_stb && (cyc - accept_cyc) < 60) @(negedge clk);
      lat = int'(cyc - accept_cyc);
      check({name, "_stb"}, {31'd0, output_z_stb}, 32'd1);
      check({name, "_lat"}, lat, exp_lat);
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
         exp = 'x;
      end else begin
         exp = sb.pop_front();
      end
      check({name, "_z"}, output_z, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({name, "_hold_stb"}, {31'd0, output_z_stb}, 32'd1);
         check({name, "_hold_z"}, output_z, exp);
      end
      output_z_ack = 1'b1;
      @(posedge clk);
      #1;
      output_z_ack = 1'b0;
      @(negedge clk);
      check({name, "_stb_clr"}, {31'd0, output_z_stb}, 32'd0);
      check({name, "_ack_low"}, {31'd0, input_a_ack}, 32'd0);
      @(negedge clk);
      check({name, "_ack_rise"}, {31'd0, input_a_ack}, 32'd1);
   endtask

   initial begin
      n_pass       = 0;
      n_total      = 0;
      cyc          = 0;
      accept_cyc   = 0;
      rst_n        = 1'b0;
      input_a      = '0;
      input_a_stb  = 1'b0;
      output_z_ack = 1'b0;

      //           a             rne           trunc         latency
      vecs[0]  = '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 34};
      vecs[1]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1};
      vecs[2]  = '{32'hFFFF_FFFF, 32'hBF80_0000, 32'hBF80_0000, 34};
      vecs[3]  = '{32'h8000_0000, 32'hCF00_0000, 32'hCF00_0000, 3};
      vecs[4]  = '{32'h0100_0001, 32'h4B80_0000, 32'h4B80_0000, 10};
      vecs[5]  = '{32'h0100_0003, 32'h4B80_0002, 32'h4B80_0001, 10};
      vecs[6]  = '{32'h7FFF_FFFF, 32'h4F00_0000, 32'h4EFF_FFFF, 4};
      vecs[7]  = '{32'h0000_0007, 32'h40E0_0000, 32'h40E0_0000, 32};
      vecs[8]  = '{32'h0000_0064, 32'h42C8_0000, 32'h42C8_0000, 28};
      vecs[9]  = '{32'hFFFF_FF9C, 32'hC2C8_0000, 32'hC2C8_0000, 28};
      vecs[10] = '{32'h00FF_FFFF, 32'h4B7F_FFFF, 32'h4B7F_FFFF, 11};
      vecs[11] = '{32'h0400_0005, 32'h4C80_0001, 32'h4C80_0000, 8};
      vecs[12] = '{32'h8000_0001, 32'hCF00_0000, 32'hCEFF_FFFF, 4};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ack", {31'd0, input_a_ack}, 32'd0);
      check("rst_stb", {31'd0, output_z_stb}, 32'd0);
      check("rst_z", output_z, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_first_ack", {31'd0, input_a_ack}, 32'd1);

      // Table-driven vectors
      for (int i = 0; i < 13; i++) begin
         drive_op(vecs[i].a, pick(vecs[i]));
         wait_result($sformatf("vec%0d", i), vecs[i].lat, 0);
      end

      // Backpressure: result held stable for 10 cycles
      drive_op(32'd100, 32'h42C8_0000);
      wait_result("bp", 28, 10);

      // Strobe pulse during NORMALISE is ignored
      drive_op(32'd1, 32'h3F80_0000);
      repeat (4) @(negedge clk);
      check("norm_ack_low", {31'd0, input_a_ack}, 32'd0);
      input_a     = 32'd5;
      input_a_stb = 1'b1;
      @(negedge clk);
      input_a_stb = 1'b0;
      wait_result("ign_stb", 34, 0);

      // Reset mid-NORMALISE, then convert 7
      drive_op(32'd1, 32'h3F80_0000);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ack", {31'd0, input_a_ack}, 32'd0);
      check("midrst_stb", {31'd0, output_z_stb}, 32'd0);
      check("midrst_z", output_z, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_ack_rise", {31'd0, input_a_ack}, 32'd1);
      drive_op(32'd7, 32'h40E0_0000);
      wait_result("post_rst", 32, 0);

      // Reset while a result is held in DONE clears the output at once
      drive_op(32'hFFFF_FF9C, 32'hC2C8_0000);
      @(negedge clk);
      while (!output_z_stb && (cyc - accept_cyc) < 60) @(negedge clk);
      check("done_rst_pre_z", output_z, sb.pop_front());
      rst_n = 1'b0;
      #1;
      check("done_rst_stb", {31'd0, output_z_stb}, 32'd0);
      check("done_rst_z", output_z, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_int_to_float

// File: doc/int_to_float.md
# int_to_float

Sequential converter from 32-bit signed two's-complement integer to IEEE-754 single precision. It sits directly upstream of the floating-point adder and supplies its `add_a`/`add_b` operands from integer sources. The datapath is a multi-cycle state machine: absolute value, one-bit-per-cycle normalisation, then round-to-nearest-even. Strobe/acknowledge handshakes sit on both sides.

## Interface
- No parameters; widths are fixed by the package constants.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `input_a`  in  32  signed integer operand.
- `input_a_stb`  in  1  operand valid.
- `input_a_ack`  out  1  registered; block can accept an operand.
- `output_z`  out  32  IEEE-754 single result.
- `output_z_stb`  out  1  registered; result valid.
- `output_z_ack`  in  1  downstream accepts the result.

## Operation
- **Reset.** While `rst_n` is low: state IDLE, `input_a_ack`=0, `output_z_stb`=0, `output_z`=0, all internal registers 0.
- **IDLE.**
  - Each edge sets `input_a_ack`=1.
  - An edge with `input_a_stb & input_a_ack` latches `input_a`, clears `input_a_ack` and moves to CONVERT.
- **CONVERT.**
  - Zero operand: `z`=0x00000000, go to DONE.
  - Otherwise: sign = a[31]; value = |a| as 32-bit unsigned (−2^31 gives 0x80000000); exponent = 31 (unbiased, 8-bit signed); go to NORMALISE.
- **NORMALISE.**
  - value[31]=0: value <<= 1, exponent −= 1, stay.
  - value[31]=1: go to ROUND.
- **ROUND.**
  - mantissa = value[31:8]; guard = value[7]; round = value[6]; sticky = |value[5:0].
  - Increment mantissa when guard & (round | sticky | mantissa[0]).
  - Carry out of 24 bits: mantissa = 0x800000 and exponent += 1.
  - Pack `output_z` = {sign, exponent+127, mantissa[22:0]}, then go to DONE.
- **DONE.**
  - `output_z_stb`=1 and `output_z` is held stable.
  - An edge with `output_z_ack`=1 clears `output_z_stb` and moves to IDLE.
- **Ignored inputs.** `input_a_stb` is ignored outside IDLE. `output_z_ack` is ignored outside DONE.
- **Range.** Exponent never leaves [127, 158] biased. No overflow, NaN or denormal outputs are possible.

## Timing
- **Latency, nonzero operand.** Let lz = leading zeros of |a|. `output_z_stb` rises lz+3 edges after the accepting edge.
  - Minimum: 3 (|a| ≥ 2^31).
  - Maximum: 34 (|a| = 1).
- **Latency, zero operand.** `output_z_stb` rises 1 edge after acceptance.
- **Back-to-back.**
  - After the DONE→IDLE edge, `input_a_ack` rises on the following edge.
  - There is no same-cycle accept/emit overlap; one conversion is in flight at a time.
- **Backpressure.** `output_z_ack` low holds DONE indefinitely with `output_z` unchanged.
- **Mid-operation reset.** Asynchronous; the in-flight conversion is discarded. After `rst_n` rises, the first edge sets `input_a_ack`.

## Configuration
- **Macro:** `INT_TO_FLOAT_ROUND_EN`.
- **Defined:** round-to-nearest-even as described under ROUND.
- **Undefined:**
  - Truncation: mantissa = value[31:8], no increment, no carry handling.
  - ROUND state is still traversed, so latency is identical in both builds.

## Structure
- **Shared package `float_pkg`:**
  - `FLOAT_WIDTH`=32, `EXP_BIAS`=127, `MANT_WIDTH`=24.
  - State encoding constants: IDLE, CONVERT, NORMALISE, ROUND, DONE.
- **Sub-module `float_round`:** combinational.
  - Inputs: 24-bit mantissa, guard, round, sticky, exponent.
  - Outputs: rounded mantissa and adjusted exponent.
  - Reused by later float blocks.
  - Contents are controlled by `INT_TO_FLOAT_ROUND_EN`.

## Test plan
- **Basic and zero values.**
  - 1 → 0x3F800000, with `output_z_stb` 34 edges after accept.
  - 0 → 0x00000000 after 1 edge.
  - −1 → 0xBF800000.
- **Most negative operand.** 0x80000000 (−2^31) → 0xCF000000 after 3 edges.
- **Tie cases, ROUND_EN defined.**
  - 16777217 → 0x4B800000 (tie, round to even, down).
  - 16777219 → 0x4B800002 (tie, round up).
- **Rounding carry.** 0x7FFFFFFF → 0x4F000000 with ROUND_EN defined.
- **Macro undefined.**
  - 16777219 → 0x4B800001.
  - 0x7FFFFFFF → 0x4EFFFFFF.
- **Handshake.**
  - Hold `output_z_ack` low for 10 cycles → `output_z`/`output_z_stb` stable.
  - Pulse `input_a_stb` during NORMALISE → ignored.
  - Assert `rst_n` low mid-NORMALISE → all outputs 0 immediately; the next operand 7 converts to 0x40E00000.
